// File: rtl/shift_cmd_queue.sv
// Command FIFO feeding a 16-bit barrel shifter, with a registered valid/ready result stage.
// Optional `SHIFT_STICKY_EN adds res_sticky, the OR of every bit shifted out.

module barrel_shift_16bit (
  input  logic [15:0] din,
  input  logic [3:0]  ctrl,
  input  logic        dir,
  input  logic        arith,
  output logic [15:0] dout
);

  // Log shifter: stage k shifts by 2**k when ctrl[k] is set; dir=1 moves toward the LSB
  always_comb begin
    logic [15:0] v;
    v = din;
    for (int k = 0; k < 4; k++) begin
      if (!ctrl[k]) begin
        v = v;
      end else if (!dir) begin
        v = v << (1 << k);
      end else if (arith) begin
        v = 16'($signed(v) >>> (1 << k));
      end else begin
        v = v >> (1 << k);
      end
    end
    dout = v;
  end

endmodule

module shift_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [15:0]                cmd_data,
  input  logic [4:0]                 cmd_amt,
  input  logic                       cmd_dir,
  input  logic                       cmd_arith,
  input  logic [TAG_W-1:0]           cmd_tag,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [15:0]                res_data,
  output logic [TAG_W-1:0]           res_tag,
`ifdef SHIFT_STICKY_EN
  output logic                       res_sticky,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [15:0]      data;
    logic [4:0]       amt;
    logic             dir;
    logic             arith;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             fifo_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r, count_next_s;
  logic             cmd_ready_r;
  logic             res_valid_r;
  logic [15:0]      res_data_r;
  logic [TAG_W-1:0] res_tag_r;
  logic             push_s, issue_s;
  cmd_t             head_s;
  logic [15:0]      shift_out_s, result_s;

  assign push_s  = cmd_valid & cmd_ready_r;
  assign issue_s = (count_r != '0) & (~res_valid_r | res_ready);
  assign head_s  = fifo_r[rd_ptr_r];

  // Left shifts never sign-fill, so arith only reaches the shifter on right shifts
  barrel_shift_16bit u_shift (
    .din   (head_s.data),
    .ctrl  (head_s.amt[3:0]),
    .dir   (head_s.dir),
    .arith (head_s.dir & head_s.arith),
    .dout  (shift_out_s)
  );

  // Amounts of 16..31 exceed the shifter range and saturate to the fill value
  always_comb begin
    result_s = shift_out_s;
    if (head_s.amt[4]) begin
      if (head_s.dir & head_s.arith) begin
        result_s = {16{head_s.data[15]}};
      end else begin
        result_s = 16'h0000;
      end
    end else begin
      result_s = shift_out_s;
    end
  end

  // Next occupancy from the push/issue pair
  always_comb begin
    count_next_s = count_r;
    case ({push_s, issue_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= '{data: cmd_data, amt: cmd_amt, dir: cmd_dir,
                            arith: cmd_arith, tag: cmd_tag};
    end
  end

  // Pointers, occupancy, registered ready and the result register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      cmd_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      res_data_r  <= 16'h0000;
      res_tag_r   <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (issue_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r     <= count_next_s;
      cmd_ready_r <= (count_next_s < DEPTH_C);
      if (issue_s) begin
        res_valid_r <= 1'b1;
        res_data_r  <= result_s;
        res_tag_r   <= head_s.tag;
      end else if (res_ready) begin
        res_valid_r <= 1'b0;
      end
    end
  end

`ifdef SHIFT_STICKY_EN
  logic [15:0] lost_mask_s;
  logic        sticky_s, res_sticky_r;

  // Mask of operand bits that leave the word; all ones once amt reaches 16
  always_comb begin
    lost_mask_s = 16'h0000;
    if (head_s.dir) begin
      lost_mask_s = ~(16'hFFFF << head_s.amt);
    end else begin
      lost_mask_s = ~(16'hFFFF >> head_s.amt);
    end
    sticky_s = |(head_s.data & lost_mask_s);
  end

  // Sticky flag loads alongside res_data
  always_ff @(posedge clk) begin
    if (rst) begin
      res_sticky_r <= 1'b0;
    end else if (issue_s) begin
      res_sticky_r <= sticky_s;
    end
  end

  assign res_sticky = res_sticky_r;
`endif

  assign cmd_ready = cmd_ready_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_tag   = res_tag_r;
  assign count     = count_r;

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Directed bench for shift_cmd_queue: hand-computed shift results, ordering,
// back-pressure, full/empty behaviour and (with SHIFT_STICKY_EN) the sticky flag.

module tb_shift_cmd_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_data;
  logic [4:0]  cmd_amt;
  logic        cmd_dir, cmd_arith;
  logic [3:0]  cmd_tag;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_tag;
  logic [2:0]  count;
`ifdef SHIFT_STICKY_EN
  logic        res_sticky;
`endif

  int checks_s   = 0;
  int failures_s = 0;
  logic [19:0] exp_q [$];

  shift_cmd_queue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_amt   (cmd_amt),
    .cmd_dir   (cmd_dir),
    .cmd_arith (cmd_arith),
    .cmd_tag   (cmd_tag),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_tag   (res_tag),
`ifdef SHIFT_STICKY_EN
    .res_sticky(res_sticky),
`endif
    .count     (count)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_s++;
    if (got !== exp) begin
      failures_s++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command until accepted, then queue its expected result
  task automatic send(input logic [15:0] d, input logic [4:0] a, input logic dr,
                      input logic ar, input logic [3:0] t, input logic [15:0] exp);
    logic acc;
    logic done;
    done = 1'b0;
    cmd_data = d; cmd_amt = a; cmd_dir = dr; cmd_arith = ar; cmd_tag = t;
    cmd_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      acc = cmd_ready;
      step();
      if (acc) begin
        exp_q.push_back({t, exp});
        done = 1'b1;
      end
    end
    if (!done) check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) step();
    check_eq("drain_left", exp_q.size(), 32'd0);
  endtask

  task automatic fill_five(input logic [3:0] tb);
    send(16'h8001, 5'd1,  1'b0, 1'b0, tb,        16'h0002);
    send(16'h8001, 5'd1,  1'b1, 1'b1, tb + 4'd1, 16'hC000);
    send(16'h1234, 5'd4,  1'b1, 1'b0, tb + 4'd2, 16'h0123);
    send(16'h00FF, 5'd15, 1'b0, 1'b0, tb + 4'd3, 16'h8000);
    send(16'h7FFF, 5'd15, 1'b1, 1'b1, tb + 4'd4, 16'h0000);
    cmd_valid = 1'b0;
  endtask

  // A result transfers at the next rising edge when valid and ready are both high here
  always @(negedge clk) begin
    logic [19:0] e;
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_res", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("res_data", res_data, e[15:0]);
        check_eq("res_tag", res_tag, e[19:16]);
      end
    end
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b1; cmd_data = 16'hBEEF; cmd_amt = 5'd1;
    cmd_dir = 1'b0; cmd_arith = 1'b0; cmd_tag = 4'hF; res_ready = 1'b0;

    // Reset with a command offered: nothing may be pushed
    step(); step();
    check_eq("rst_res_valid", res_valid, 32'd0);
    check_eq("rst_count", count, 32'd0);
    check_eq("rst_cmd_ready", cmd_ready, 32'd1);
    check_eq("rst_res_data", res_data, 32'd0);
    check_eq("rst_res_tag", res_tag, 32'd0);
    rst = 1'b0; cmd_valid = 1'b0;
    step();
    check_eq("rst_no_push", count, 32'd0);

    // Basic shifts, tags returned in order
    res_ready = 1'b1;
    send(16'hD011, 5'd4, 1'b1, 1'b1, 4'd1, 16'hFD01);
    send(16'hD011, 5'd4, 1'b1, 1'b0, 4'd2, 16'h0D01);
    send(16'hD011, 5'd8, 1'b0, 1'b0, 4'd3, 16'h1100);
    send(16'hD011, 5'd0, 1'b1, 1'b1, 4'd4, 16'hD011);
    cmd_valid = 1'b0;
    drain();

    // Saturating amounts
    send(16'hD011, 5'd20, 1'b1, 1'b1, 4'd5, 16'hFFFF);
    send(16'hD011, 5'd20, 1'b1, 1'b0, 4'd6, 16'h0000);
    send(16'hD011, 5'd20, 1'b0, 1'b1, 4'd7, 16'h0000);
    cmd_valid = 1'b0;
    drain();

    // Back-pressure: one held result plus four queued
    res_ready = 1'b0;
    fill_five(4'd1);
    check_eq("full_count", count, 32'd4);
    check_eq("full_ready", cmd_ready, 32'd0);
    check_eq("full_res_valid", res_valid, 32'd1);
    step(); step();
    check_eq("hold_data", res_data, 32'h0002);
    check_eq("hold_tag", res_tag, 32'd1);
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check_eq("drain_rate", exp_q.size(), 32'd0);
    check_eq("drain_res_valid", res_valid, 32'd0);
    check_eq("drain_count", count, 32'd0);

    // Full with a pop: ready stays low that edge, then push+pop keeps count
    res_ready = 1'b0;
    fill_five(4'd8);
    cmd_data = 16'h8000; cmd_amt = 5'd31; cmd_dir = 1'b1; cmd_arith = 1'b1;
    cmd_tag = 4'd13; cmd_valid = 1'b1; res_ready = 1'b1;
    check_eq("full_pop_ready_pre", cmd_ready, 32'd0);
    step();
    check_eq("full_pop_count", count, 32'd3);
    check_eq("full_pop_ready", cmd_ready, 32'd1);
    exp_q.push_back({4'd13, 16'hFFFF});
    step();
    check_eq("push_pop_count", count, 32'd3);
    cmd_valid = 1'b0;
    drain();

    // Continuous streaming: occupancy stays at one
    for (int i = 0; i < 6; i++) begin
      cmd_data = 16'h0003; cmd_amt = 5'(i); cmd_dir = 1'b0; cmd_arith = 1'b0;
      cmd_tag = 4'(i); cmd_valid = 1'b1;
      step();
      exp_q.push_back({4'(i), 16'h0003 << i});
      check_eq("stream_count", count, 32'd1);
      check_eq("stream_ready", cmd_ready, 32'd1);
      if (i > 0) check_eq("stream_res_valid", res_valid, 32'd1);
    end
    cmd_valid = 1'b0;
    drain();

    // Reset mid-operation discards the held result and queue
    res_ready = 1'b0;
    send(16'h1111, 5'd1, 1'b0, 1'b0, 4'd1, 16'h2222);
    send(16'h1111, 5'd2, 1'b0, 1'b0, 4'd2, 16'h4444);
    cmd_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check_eq("mid_rst_valid", res_valid, 32'd0);
    check_eq("mid_rst_count", count, 32'd0);
    check_eq("mid_rst_data", res_data, 32'd0);

`ifdef SHIFT_STICKY_EN
    begin
      logic [15:0] sd [4] = '{16'hD011, 16'hD010, 16'hD011, 16'h0000};
      logic [4:0]  sa [4] = '{5'd4, 5'd4, 5'd8, 5'd20};
      logic        sr [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [15:0] se [4] = '{16'h0D01, 16'h0D01, 16'h1100, 16'h0000};
      logic        ss [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
        res_ready = 1'b0;
        send(sd[i], sa[i], sr[i], 1'b0, 4'(i), se[i]);
        cmd_valid = 1'b0;
        step();
        check_eq("sticky", res_sticky, 32'(ss[i]));
        res_ready = 1'b1;
        drain();
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
    $finish;
  end

endmodule
